soc_health_monitor: RTL and testbench

//  Synthesizable, parametrised run-health checker for the RV32IM SoC; replaces ad-hoc bench watchdogs.

---
 rtl/soc_health_monitor.sv | 162 ++++++++++++++++
 tb/tb_soc_health_monitor.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/soc_health_monitor.sv
// soc_health_monitor: run-health checker for the RV32IM SoC.
// Watches NUM_CH value channels for progress, flags per-channel stalls,
// enforces a global run timeout and latches a PASS/FAIL/TIMEOUT verdict.
// Optional feature macro: HEALTH_MON_SNAPSHOT_EN. When it is defined,
// channel values are captured on entry to a verdict. Otherwise snap_val
// is tied to zero.
module soc_health_monitor #(
  parameter int unsigned NUM_CH         = 4,
  parameter int unsigned CH_W           = 32,
  parameter int unsigned STALL_CYCLES   = 1000,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   enable,
  input  logic                   clear,
  input  logic [NUM_CH-1:0]      ch_mask,
  input  logic [NUM_CH*CH_W-1:0] ch_val,
  input  logic                   pass_req,
  output logic [2:0]             state,
  output logic [NUM_CH-1:0]      ch_alive,
  output logic [NUM_CH-1:0]      ch_stalled,
  output logic [31:0]            cycle_count,
  output logic [NUM_CH*CH_W-1:0] snap_val
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RUN     = 3'd1,
    S_PASS    = 3'd2,
    S_FAIL    = 3'd3,
    S_TIMEOUT = 3'd4
  } state_t;

  localparam int unsigned   SC_W        = $clog2(STALL_CYCLES + 1);
  localparam logic [SC_W-1:0] STALL_MAX = SC_W'(STALL_CYCLES);
  localparam logic [SC_W-1:0] STALL_PRE = SC_W'(STALL_CYCLES - 1);
  localparam logic [31:0]   TIMEOUT_VAL = 32'(TIMEOUT_CYCLES);

  state_t state_q, state_d;

  logic [NUM_CH-1:0][CH_W-1:0] ch_arr;
  logic [NUM_CH-1:0][CH_W-1:0] prev_q;
  logic [NUM_CH-1:0][SC_W-1:0] stall_cnt_q;
  logic [NUM_CH-1:0]           alive_q;
  logic [NUM_CH-1:0]           stalled_q;
  logic [31:0]                 cycle_q;

  logic [NUM_CH-1:0] ch_change;
  logic [NUM_CH-1:0] stall_hit;
  logic              fail_cond;
  logic              timeout_cond;
  logic              arm;
  logic              run_step;
  logic              to_idle;

  // Packed 2-D view places channel i at ch_val[i*CH_W +: CH_W].
  assign ch_arr = ch_val;

  // Per-channel change detection and the stall threshold crossing.
  always_comb begin
    ch_change = '0;
    stall_hit = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      ch_change[i] = (ch_arr[i] != prev_q[i]);
      stall_hit[i] = !ch_change[i] && (stall_cnt_q[i] == STALL_PRE);
    end
  end

  // Verdict conditions, evaluated from registered status.
  always_comb begin
    fail_cond    = 1'b0;
    timeout_cond = 1'b0;
    fail_cond    = (|(ch_mask & stalled_q)) || (pass_req && (|(ch_mask & ~alive_q)));
    timeout_cond = (cycle_q == TIMEOUT_VAL);
  end

  // Next-state logic and the per-edge control strobes.
  always_comb begin
    state_d  = state_q;
    if (clear) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: if (enable) state_d = S_RUN;
        S_RUN: begin
          if (!enable)           state_d = S_IDLE;
          else if (fail_cond)    state_d = S_FAIL;
          else if (timeout_cond) state_d = S_TIMEOUT;
          else if (pass_req)     state_d = S_PASS;
        end
        S_PASS, S_FAIL, S_TIMEOUT: if (!enable) state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
    arm      = (state_q == S_IDLE) && (state_d == S_RUN);
    // The verdict edge itself leaves status untouched, so the frozen
    // values are the ones that caused the verdict.
    run_step = (state_q == S_RUN) && (state_d == S_RUN);
    to_idle  = (state_d == S_IDLE);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Sticky status and the saturating run-cycle counter.
  always_ff @(posedge clk) begin
    if (!rst_n || to_idle || arm) begin
      cycle_q   <= '0;
      alive_q   <= '0;
      stalled_q <= '0;
    end else if (run_step) begin
      if (cycle_q != '1) cycle_q <= cycle_q + 32'd1;
      alive_q   <= alive_q | ch_change;
      stalled_q <= stalled_q | stall_hit;
    end
  end

  // Previous-value tracking and per-channel unchanged-cycle counters.
  always_ff @(posedge clk) begin
    if (!rst_n || to_idle) begin
      prev_q      <= '0;
      stall_cnt_q <= '0;
    end else if (arm) begin
      prev_q      <= ch_arr;
      stall_cnt_q <= '0;
    end else if (run_step) begin
      prev_q <= ch_arr;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        if (ch_change[i])                     stall_cnt_q[i] <= '0;
        else if (stall_cnt_q[i] != STALL_MAX) stall_cnt_q[i] <= stall_cnt_q[i] + SC_W'(1);
      end
    end
  end

`ifdef HEALTH_MON_SNAPSHOT_EN
  logic [NUM_CH*CH_W-1:0] snap_q;
  logic                   enter_term;

  assign enter_term = (state_q == S_RUN) &&
                      ((state_d == S_PASS) || (state_d == S_FAIL) || (state_d == S_TIMEOUT));

  // Capture channel values on the edge that enters a verdict.
  always_ff @(posedge clk) begin
    if (!rst_n || to_idle) snap_q <= '0;
    else if (enter_term)   snap_q <= ch_val;
  end

  assign snap_val = snap_q;
`else
  assign snap_val = '0;
`endif

  assign state       = state_q;
  assign ch_alive    = alive_q;
  assign ch_stalled  = stalled_q;
  assign cycle_count = cycle_q;

endmodule

// File: tb/tb_soc_health_monitor.sv
// Self-checking bench for soc_health_monitor (NUM_CH=2, CH_W=8,
// STALL_CYCLES=8, TIMEOUT_CYCLES=64). A behavioural reference model
// tracks run lengths of unchanged samples and applies the verdict rules.
module tb_soc_health_monitor;

  localparam int NCH = 2;
  localparam int STALL = 8;
  localparam int TMO = 64;

  logic        clk;
  logic        rst_n;
  logic        enable;
  logic        clear;
  logic [1:0]  ch_mask;
  logic [15:0] ch_val;
  logic        pass_req;
  logic [2:0]  state;
  logic [1:0]  ch_alive;
  logic [1:0]  ch_stalled;
  logic [31:0] cycle_count;
  logic [15:0] snap_val;

  int errors = 0;
  int checks = 0;

  // Reference model state
  int          m_state;
  int unsigned m_cnt;
  logic [1:0]  m_alive;
  logic [1:0]  m_stalled;
  int          m_run [NCH];
  logic [7:0]  m_prev [NCH];
  logic [15:0] m_snap;

  logic [7:0] c0, c1;

  soc_health_monitor #(
    .NUM_CH(2),
    .CH_W(8),
    .STALL_CYCLES(8),
    .TIMEOUT_CYCLES(64)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .enable(enable),
    .clear(clear),
    .ch_mask(ch_mask),
    .ch_val(ch_val),
    .pass_req(pass_req),
    .state(state),
    .ch_alive(ch_alive),
    .ch_stalled(ch_stalled),
    .cycle_count(cycle_count),
    .snap_val(snap_val)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_idle();
    m_state   = 0;
    m_cnt     = 0;
    m_alive   = '0;
    m_stalled = '0;
    m_snap    = '0;
    for (int i = 0; i < NCH; i++) m_run[i] = 0;
  endtask

  // Advance the model by one clock edge using the inputs currently applied.
  task automatic step_model();
    logic [7:0] v [NCH];
    bit fail;
    v[0] = ch_val[7:0];
    v[1] = ch_val[15:8];
    if (!rst_n || clear) begin
      model_idle();
    end else if (m_state == 0) begin
      if (enable) begin
        m_state = 1;
        m_cnt   = 0;
        for (int i = 0; i < NCH; i++) begin
          m_prev[i] = v[i];
          m_run[i]  = 0;
        end
      end
    end else if (!enable) begin
      model_idle();
    end else if (m_state == 1) begin
      fail = ((ch_mask & m_stalled) != 2'b00) ||
             (pass_req && ((ch_mask & ~m_alive) != 2'b00));
      if (fail) begin
        m_state = 3; m_snap = ch_val;
      end else if (m_cnt == TMO) begin
        m_state = 4; m_snap = ch_val;
      end else if (pass_req) begin
        m_state = 2; m_snap = ch_val;
      end else begin
        m_cnt++;
        for (int i = 0; i < NCH; i++) begin
          if (v[i] != m_prev[i]) begin
            m_alive[i] = 1'b1;
            m_run[i]   = 0;
          end else begin
            m_run[i]++;
            if (m_run[i] >= STALL) m_stalled[i] = 1'b1;
          end
          m_prev[i] = v[i];
        end
      end
    end
  endtask

  task automatic check_all();
    cmp("state", 32'(state), 32'(m_state));
    cmp("cycle_count", cycle_count, m_cnt);
    cmp("ch_alive", 32'(ch_alive), 32'(m_alive));
    cmp("ch_stalled", 32'(ch_stalled), 32'(m_stalled));
`ifdef HEALTH_MON_SNAPSHOT_EN
    cmp("snap_val", 32'(snap_val), 32'(m_snap));
`else
    cmp("snap_val", 32'(snap_val), 32'd0);
`endif
  endtask

  task automatic tick();
    step_model();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic set_ch();
    ch_val = {c1, c0};
  endtask

  task automatic clear_pulse();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  initial begin
    int k;
    rst_n = 1'b0; enable = 1'b1; clear = 1'b0; pass_req = 1'b0; ch_mask = 2'b11;
    c0 = 8'($urandom); c1 = 8'($urandom); set_ch();
    model_idle();
    for (int i = 0; i < NCH; i++) m_prev[i] = '0;

    // 1: reset with enable held high
    for (int t = 0; t < 3; t++) tick();
    cmp("reset_state", 32'(state), 32'd0);
    cmp("reset_cnt", cycle_count, 32'd0);
    cmp("reset_alive", 32'(ch_alive), 32'd0);
    cmp("reset_snap", 32'(snap_val), 32'd0);

    // 2: progress on both channels, pass request at count 21
    rst_n = 1'b1;
    k = 0;
    for (int t = 0; t < 60 && !(m_state == 1 && m_cnt == 21); t++) begin
      tick(); k++;
      if (k % 3 == 0) begin c0 = c0 + 8'd1; c1 = c1 + 8'd1; set_ch(); end
    end
    cmp("pass_reach_cnt", cycle_count, 32'd21);
    pass_req = 1'b1; tick(); pass_req = 1'b0;
    cmp("pass_state", 32'(state), 32'd2);
    cmp("pass_alive", 32'(ch_alive), 32'd3);
    cmp("pass_stalled", 32'(ch_stalled), 32'd0);
    for (int t = 0; t < 3; t++) begin c0 = c0 + 8'd1; set_ch(); tick(); end
    cmp("pass_frozen_cnt", cycle_count, 32'd21);

    // 3: ch1 held at A5, ch0 toggles every cycle
    clear_pulse();
    c1 = 8'hA5; c0 = 8'($urandom); set_ch();
    for (int t = 0; t < 40 && m_state != 3; t++) begin
      tick();
      c0 = ~c0; set_ch();
    end
    cmp("stall_state", 32'(state), 32'd3);
    cmp("stall_bits", 32'(ch_stalled), 32'd2);
    cmp("stall_cnt", cycle_count, 32'd8);
`ifdef HEALTH_MON_SNAPSHOT_EN
    cmp("stall_snap_hi", 32'(snap_val[15:8]), 32'hA5);
`else
    cmp("stall_snap_zero", 32'(snap_val), 32'd0);
`endif

    // 4: steady progress every 4 cycles, no pass request
    clear_pulse();
    k = 0;
    for (int t = 0; t < 100 && m_state < 2; t++) begin
      tick(); k++;
      if (k % 4 == 0) begin
        c0 = c0 ^ 8'($urandom_range(1, 255));
        c1 = c1 ^ 8'($urandom_range(1, 255));
        set_ch();
      end
    end
    cmp("tmo_state", 32'(state), 32'd4);
    cmp("tmo_cnt", cycle_count, 32'd64);
    cmp("tmo_stalled", 32'(ch_stalled), 32'd0);

    // 5a: unmasked ch1 stalls without causing a verdict
    ch_mask = 2'b01;
    clear_pulse();
    for (int t = 0; t < 20; t++) begin tick(); c0 = ~c0; set_ch(); end
    cmp("mask_state_run", 32'(state), 32'd1);
    cmp("mask_stalled", 32'(ch_stalled), 32'd2);
    pass_req = 1'b1; tick(); pass_req = 1'b0;
    cmp("mask_pass", 32'(state), 32'd2);

    // 5b: both masked channels stall together with a pass request
    ch_mask = 2'b11;
    clear_pulse();
    for (int t = 0; t < 20 && m_stalled != 2'b11; t++) tick();
    pass_req = 1'b1; tick(); pass_req = 1'b0;
    cmp("prio_fail", 32'(state), 32'd3);

    // 5c: empty mask, stalls everywhere, pass request still passes
    ch_mask = 2'b00;
    clear_pulse();
    for (int t = 0; t < 12; t++) tick();
    pass_req = 1'b1; tick(); pass_req = 1'b0;
    cmp("nomask_pass", 32'(state), 32'd2);

    // 5d: pass request while a masked channel has never changed
    ch_mask = 2'b11;
    clear_pulse();
    for (int t = 0; t < 4; t++) begin tick(); c0 = ~c0; set_ch(); end
    pass_req = 1'b1; tick(); pass_req = 1'b0;
    cmp("dead_ch_fail", 32'(state), 32'd3);

    // 6: clear pulse mid-run, then automatic re-arm; then enable drop
    clear_pulse();
    k = 0;
    for (int t = 0; t < 30 && !(m_state == 1 && m_cnt == 10); t++) begin
      tick(); k++;
      if (k % 2 == 0) begin c0 = c0 + 8'd3; c1 = c1 - 8'd5; set_ch(); end
    end
    clear_pulse();
    cmp("abort_state", 32'(state), 32'd0);
    cmp("abort_cnt", cycle_count, 32'd0);
    cmp("abort_alive", 32'(ch_alive), 32'd0);
    tick();
    cmp("rearm_state", 32'(state), 32'd1);
    cmp("rearm_cnt", cycle_count, 32'd0);
    tick();
    cmp("rearm_cnt1", cycle_count, 32'd1);
    enable = 1'b0; tick(); enable = 1'b1;
    cmp("disable_state", 32'(state), 32'd0);

    // Randomized phase against the reference model
    for (int t = 0; t < 1500; t++) begin
      if ($urandom_range(0, 5) == 0) c0 = 8'($urandom);
      if ($urandom_range(0, 5) == 0) c1 = 8'($urandom);
      set_ch();
      pass_req = ($urandom_range(0, 39) == 0);
      clear    = ($urandom_range(0, 99) == 0);
      enable   = ($urandom_range(0, 59) != 0);
      if ($urandom_range(0, 49) == 0) ch_mask = 2'($urandom);
      tick();
    end
    pass_req = 1'b0; clear = 1'b0; enable = 1'b1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
